// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline latch.
// Holds the control state encoding, the default NOP instruction word and
// the payload lane indices used by every pipeline stage boundary.
package pipe_pkg;

   // Occupancy of the latch: no entry, main entry only, main plus skid entry.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   // Instruction word driven on lane 0 while the latch holds nothing.
   localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;

   // Payload lane assignment shared by all stage boundaries.
   localparam int unsigned LANE_INSN = 0;
   localparam int unsigned LANE_ALU  = 1;
   localparam int unsigned LANE_MEM  = 2;
   localparam int unsigned LANE_MD   = 3;
   localparam int unsigned LANE_MDI  = 4;

endpackage

// File: rtl/pipe_reg_w.sv
// One lane of latch storage: DATA_W-bit register with load enable.
// Latency: loaded value visible right after the selected capture edge.
// Backpressure: none of its own; holds its value whenever en_i is low.
// Ports: clk_i stage clock, rst_ni async active-low clear, en_i load enable,
//        d_i next value, q_o held value.
module pipe_reg_w #(
   parameter int unsigned DATA_W   = 32,
   parameter bit          NEG_EDGE = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   // Capture edge selection: every flop in the latch samples on the
   // rising edge of this derived clock, so all of them agree on the edge.
   logic              cap_clk;
   logic [DATA_W-1:0] data_q;

   assign cap_clk = NEG_EDGE ? ~clk_i : clk_i;

   always_ff @(posedge cap_clk or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic inter-stage latch: LANES x DATA_W payload under valid/ready, optional skid entry.
// Latency: a beat accepted into an empty or draining latch is on out_data right after the capture edge.
// Backpressure: SKID=1 registered in_ready (low only when both entries full); SKID=0 in_ready = !out_valid | out_ready.
// Ports: clock/reset (async active-low), flush kills held and incoming beats,
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream,
//        bubble_cnt saturating count of edges where downstream was ready but nothing was offered.
module pipe_latch_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        LANES    = 5,
   parameter bit                 SKID     = 1'b1,
   parameter bit                 NEG_EDGE = 1'b1,
   parameter logic [DATA_W-1:0]  NOP_INSN = DATA_W'(NOP_INSN_DEFAULT),
   parameter int unsigned        CNT_W    = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [CNT_W-1:0]          bubble_cnt
);

   localparam int unsigned W = LANES * DATA_W;

   logic          cap_clk;
   pipe_state_e   state_q, state_d;
   logic [CNT_W-1:0] bub_q, bub_d;
   logic          in_fire, out_fire;
   logic          main_en, skid_en, main_from_skid;
   logic [W-1:0]  main_q, skid_q, main_d;

   assign cap_clk   = NEG_EDGE ? ~clock : clock;
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Next-state and storage enables. Flush overrides everything and also
   // suppresses the loads, so a killed beat never reaches storage.
   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d = ONE;
               main_en = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_en = 1'b1;
            end else if (in_fire) begin
               // Only reachable with the skid entry: without it in_ready
               // is low whenever the head is held.
               state_d = TWO;
               skid_en = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_d        = ONE;
               main_en        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_en = 1'b0;
         skid_en = 1'b0;
      end
   end

   // Counts edges where downstream was ready but the latch offered nothing.
   always_comb begin
      bub_d = bub_q;
      if (out_ready && !out_valid && (bub_q != {CNT_W{1'b1}})) begin
         bub_d = bub_q + CNT_W'(1);
      end
   end

   always_ff @(posedge cap_clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         bub_q   <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
      end
   end

   assign bubble_cnt = bub_q;

   if (SKID) begin : g_skid
      logic in_ready_q;

      // Ready is decided from the next occupancy so it is a plain flop
      // output with no path back from out_ready.
      always_ff @(posedge cap_clk or negedge reset) begin
         if (!reset) begin
            in_ready_q <= 1'b1;
         end else begin
            in_ready_q <= (state_d != TWO);
         end
      end

      assign in_ready = in_ready_q;

      for (genvar k = 0; k < LANES; k++) begin : g_lane
         pipe_reg_w #(
            .DATA_W   (DATA_W),
            .NEG_EDGE (NEG_EDGE)
         ) u_skid (
            .clk_i  (clock),
            .rst_ni (reset),
            .en_i   (skid_en),
            .d_i    (in_data[k*DATA_W +: DATA_W]),
            .q_o    (skid_q[k*DATA_W +: DATA_W])
         );
      end
   end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
      assign skid_q   = '0;
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   for (genvar k = 0; k < LANES; k++) begin : g_main
      pipe_reg_w #(
         .DATA_W   (DATA_W),
         .NEG_EDGE (NEG_EDGE)
      ) u_main (
         .clk_i  (clock),
         .rst_ni (reset),
         .en_i   (main_en),
         .d_i    (main_d[k*DATA_W +: DATA_W]),
         .q_o    (main_q[k*DATA_W +: DATA_W])
      );
   end

   // Downstream decodes lane 0 as an instruction, so an empty latch must
   // present a harmless NOP there; other lanes keep their last contents.
   always_comb begin
      out_data = main_q;
      if (!out_valid) begin
         out_data[LANE_INSN*DATA_W +: DATA_W] = NOP_INSN;
      end
   end

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Testbench for pipe_latch_elastic (SKID=1, falling-edge capture, 4-bit counter).
// Model: FIFO queue of depth 2 plus a saturating integer, updated on the capture edge.
// Outputs compared against the model on every rising edge; directed literals pin key points.
module tb_pipe_latch_elastic;

   localparam int DW = 32;
   localparam int LN = 5;
   localparam int W  = DW * LN;
   localparam int CW = 4;

   logic          clock     = 1'b0;
   logic          reset     = 1'b1;
   logic          flush     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_data   = '0;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [CW-1:0] bubble_cnt;

   int n_vec = 0;
   int n_err = 0;

   pipe_latch_elastic #(
      .DATA_W   (DW),
      .LANES    (LN),
      .SKID     (1'b1),
      .NEG_EDGE (1'b1),
      .NOP_INSN (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clock = ~clock;

   // Behavioural reference: the latch is a FIFO of at most two beats.
   logic [W-1:0] mq[$];
   int           mbub = 0;

   always @(negedge reset) begin
      mq.delete();
      mbub = 0;
   end

   always @(negedge clock) begin
      bit v, ir;
      if (reset) begin
         v  = (mq.size() > 0);
         ir = (mq.size() < 2);
         if (out_ready && !v && mbub < 15) mbub = mbub + 1;
         if (flush) begin
            mq.delete();
         end else begin
            if (v && out_ready) void'(mq.pop_front());
            if (in_valid && ir) mq.push_back(in_data);
         end
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Per-cycle comparison, half a period away from the capture edge.
   always @(posedge clock) begin
      logic [W-1:0] head;
      head = (mq.size() > 0) ? mq[0] : '0;
      chk("out_valid", W'(out_valid), W'(mq.size() > 0));
      chk("in_ready", W'(in_ready), W'(mq.size() < 2));
      chk("lane0", W'(out_data[DW-1:0]), W'(head[DW-1:0]));
      if (mq.size() > 0) chk("payload", out_data, head);
      chk("bubble_cnt", W'(bubble_cnt), W'(mbub));
   end

   function automatic logic [W-1:0] beat(input logic [31:0] x);
      logic [W-1:0] b;
      for (int k = 0; k < LN; k++) b[k*DW +: DW] = x + 32'(k) * 32'h0100_0000;
      return b;
   endfunction

   // Drive one set of inputs and advance past the next capture edge.
   task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clock);
      #1;
   endtask

   initial begin
      logic [W-1:0] rd;
      #1 reset = 1'b0;
      #2;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_data", out_data, '0);
      chk("rst_bubble", W'(bubble_cnt), W'(0));
      @(negedge clock);
      #1 reset = 1'b1;

      // Idle with downstream ready: three bubbles.
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);
      chk("idle_bubble", W'(bubble_cnt), W'(4'd3));
      chk("idle_out_data", out_data, '0);
      chk("idle_out_valid", W'(out_valid), W'(0));

      // Streaming, one beat per edge.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, beat(32'hA0 + 32'(i)), 1'b1, 1'b0);
         chk("stream_lane0", W'(out_data[DW-1:0]), W'(32'hA0 + 32'(i)));
         chk("stream_in_ready", W'(in_ready), W'(1));
      end
      step(1'b0, '0, 1'b1, 1'b0);
      chk("stream_drain", W'(out_valid), W'(0));

      // Backpressure fills the skid entry.
      step(1'b1, beat(32'hB0), 1'b0, 1'b0);
      step(1'b1, beat(32'hB1), 1'b0, 1'b0);
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_head", out_data, beat(32'hB0));
      step(1'b0, '0, 1'b0, 1'b0);
      chk("bp_hold", out_data, beat(32'hB0));
      step(1'b0, '0, 1'b1, 1'b0);
      chk("bp_second", out_data, beat(32'hB1));
      chk("bp_ready_back", W'(in_ready), W'(1));
      step(1'b0, '0, 1'b1, 1'b0);
      chk("bp_empty", W'(out_valid), W'(0));
      chk("bp_bubble", W'(bubble_cnt), W'(4'd4));

      // Flush from TWO and from ONE with an incoming beat.
      step(1'b1, beat(32'hC0), 1'b0, 1'b0);
      step(1'b1, beat(32'hC1), 1'b0, 1'b0);
      step(1'b1, beat(32'hC2), 1'b0, 1'b1);
      chk("flush_two_valid", W'(out_valid), W'(0));
      chk("flush_keeps_bubble", W'(bubble_cnt), W'(4'd4));
      step(1'b1, beat(32'hC3), 1'b0, 1'b0);
      chk("flush_c3", W'(out_data[DW-1:0]), W'(32'hC3));
      step(1'b1, beat(32'hC4), 1'b1, 1'b1);
      chk("flush_one_valid", W'(out_valid), W'(0));
      step(1'b0, '0, 1'b1, 1'b0);
      chk("flush_dropped", W'(out_valid), W'(0));
      chk("flush_bubble", W'(bubble_cnt), W'(4'd5));

      // Counter saturation.
      repeat (20) step(1'b0, '0, 1'b1, 1'b0);
      chk("sat", W'(bubble_cnt), W'(4'hF));
      step(1'b0, '0, 1'b1, 1'b0);
      chk("sat_hold", W'(bubble_cnt), W'(4'hF));

      // Asynchronous reset while holding one entry.
      step(1'b1, beat(32'hD0), 1'b0, 1'b0);
      chk("d0_held", W'(out_data[DW-1:0]), W'(32'hD0));
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", W'(out_valid), W'(0));
      chk("arst_bubble", W'(bubble_cnt), W'(0));
      chk("arst_in_ready", W'(in_ready), W'(1));
      chk("arst_data", out_data, '0);
      @(posedge clock);
      #1 reset = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0);
      chk("arst_no_d0", W'(out_valid), W'(0));
      chk("arst_bubble_after", W'(bubble_cnt), W'(4'd1));

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < LN; k++) rd[k*DW +: DW] = $urandom;
         step(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0));
      end

      @(posedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
